// File: rtl/forth_cpu.sv
// J1-style 16-bit dual-stack Forth core: one instruction per clock from a
// synchronous ROM, with a combinational-read data RAM outside the block.
module forth_cpu #(
  parameter int DSTACK_DEPTH = 16,
  parameter int RSTACK_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [9:0]  iaddr,
  input  logic [15:0] idata,
  output logic [7:0]  daddr,
  output logic [15:0] ddata_write,
  input  logic [15:0] ddata_read,
  output logic        dwrite
);
  localparam int DW = $clog2(DSTACK_DEPTH);
  localparam int RW = $clog2(RSTACK_DEPTH);

  logic [9:0]    pc_q, pc_d, pc_inc;
  logic          valid_q;
  logic [15:0]   t_q, t_d;
  logic [DW-1:0] dsp_q, dsp_d, dsp_delta;
  logic [RW-1:0] rsp_q, rsp_d, rsp_delta;
  logic [15:0]   dstack_q [DSTACK_DEPTH];
  logic [15:0]   rstack_q [RSTACK_DEPTH];
  logic          dpush, rpush;
  logic [15:0]   rpush_val;
  logic [15:0]   n_w, r_w, alu_res;
  logic          is_lit, is_jmp, is_zbr, is_call, is_alu;
  logic          unused_idata;

  assign n_w       = dstack_q[dsp_q];
  assign r_w       = rstack_q[rsp_q];
  assign pc_inc    = pc_q + 10'd1;
  assign is_lit    = ~idata[15];
  assign is_jmp    = idata[15:13] == 3'b100;
  assign is_zbr    = idata[15:13] == 3'b101;
  assign is_call   = idata[15:13] == 3'b110;
  assign is_alu    = idata[15:13] == 3'b111;
  assign dsp_delta = DW'($signed(idata[1:0]));
  assign rsp_delta = RW'($signed(idata[8:7]));
  assign unused_idata = idata[2];

  always_comb begin
    alu_res = t_q;
    case (idata[6:3])
      4'd0:    alu_res = t_q + n_w;
      4'd1:    alu_res = t_q & n_w;
      4'd2:    alu_res = t_q | n_w;
      4'd3:    alu_res = t_q ^ n_w;
      4'd4:    alu_res = ~t_q;
      4'd5:    alu_res = (n_w == t_q) ? 16'hFFFF : 16'h0000;
      4'd6:    alu_res = ($signed(n_w) < $signed(t_q)) ? 16'hFFFF : 16'h0000;
      4'd7:    alu_res = n_w >> t_q[3:0];
      4'd8:    alu_res = t_q;
      4'd9:    alu_res = n_w;
      4'd10:   alu_res = r_w;
      4'd11:   alu_res = ddata_read;
      4'd12:   alu_res = n_w << t_q[3:0];
      4'd13:   alu_res = t_q - 16'd1;
      4'd14:   alu_res = 16'(dsp_q);
      default: alu_res = n_w - t_q;
    endcase
  end

  // The bubble re-presents address 0 so the first executed word is ROM[0].
  always_comb begin
    pc_d      = pc_q;
    t_d       = t_q;
    dsp_d     = dsp_q;
    rsp_d     = rsp_q;
    dpush     = 1'b0;
    rpush     = 1'b0;
    rpush_val = t_q;
    if (valid_q) begin
      pc_d = pc_inc;
      if (is_lit) begin
        t_d   = {1'b0, idata[14:0]};
        dsp_d = dsp_q + DW'(1);
        dpush = 1'b1;
      end else if (is_jmp) begin
        pc_d = idata[9:0];
      end else if (is_zbr) begin
        t_d   = n_w;
        dsp_d = dsp_q - DW'(1);
        if (t_q == 16'd0) pc_d = idata[9:0];
      end else if (is_call) begin
        rsp_d     = rsp_q + RW'(1);
        rpush     = 1'b1;
        rpush_val = {6'd0, pc_inc};
        pc_d      = idata[9:0];
      end else begin
        t_d   = alu_res;
        dsp_d = dsp_q + dsp_delta;
        rsp_d = rsp_q + rsp_delta;
        dpush = idata[11];
        rpush = idata[10];
        if (idata[12]) pc_d = r_w[9:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= 10'd0;
      valid_q <= 1'b0;
      t_q     <= 16'd0;
      dsp_q   <= '0;
      rsp_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      t_q     <= t_d;
      dsp_q   <= dsp_d;
      rsp_q   <= rsp_d;
    end
  end

  for (genvar gi = 0; gi < DSTACK_DEPTH; gi++) begin : g_dstack
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                            dstack_q[gi] <= 16'd0;
      else if (dpush && dsp_d == DW'(gi))    dstack_q[gi] <= t_q;
    end
  end

  for (genvar gi = 0; gi < RSTACK_DEPTH; gi++) begin : g_rstack
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                            rstack_q[gi] <= 16'd0;
      else if (rpush && rsp_d == RW'(gi))    rstack_q[gi] <= rpush_val;
    end
  end

  assign iaddr       = pc_d;
  assign daddr       = t_q[7:0];
  assign ddata_write = n_w;
  assign dwrite      = valid_q & is_alu & idata[9];
endmodule

// File: tb/tb_forth_cpu.sv
// Bench for forth_cpu: ISA-level reference model checked every cycle, plus
// directed programs with hand-computed expectations.
module tb_forth_cpu;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  iaddr;
  logic [15:0] idata;
  logic [7:0]  daddr;
  logic [15:0] ddata_write;
  logic [15:0] ddata_read;
  logic        dwrite;

  logic [15:0] rom [1024];
  logic [15:0] ram [256];
  int checks = 0;
  int errors = 0;

  // reference model state
  logic [9:0]  m_pc;
  logic [15:0] m_T;
  int          m_dsp, m_rsp;
  bit          m_valid;
  logic [15:0] m_ds [16];
  logic [15:0] m_rs [16];
  logic [15:0] m_ram [256];
  logic [15:0] insn, mn, mr, res;
  logic [9:0]  npc;
  int          nd, nr;
  logic        exp_dw;

  always #5 clk = ~clk;

  forth_cpu #(.DSTACK_DEPTH(16), .RSTACK_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .iaddr(iaddr), .idata(idata), .daddr(daddr),
    .ddata_write(ddata_write), .ddata_read(ddata_read), .dwrite(dwrite)
  );

  always @(posedge clk) begin
    idata <= rom[iaddr];
    if (dwrite) ram[daddr] <= ddata_write;
  end
  assign ddata_read = ram[daddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int delta(input logic [1:0] d);
    case (d)
      2'b01:   return 1;
      2'b11:   return -1;
      2'b10:   return -2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] t, n, r, rd,
                                      input int depth);
    case (op)
      4'd0:  return t + n;
      4'd1:  return t & n;
      4'd2:  return t | n;
      4'd3:  return t ^ n;
      4'd4:  return ~t;
      4'd5:  return (n == t) ? 16'hFFFF : 16'h0000;
      4'd6:  return ($signed(n) < $signed(t)) ? 16'hFFFF : 16'h0000;
      4'd7:  return n >> t[3:0];
      4'd8:  return t;
      4'd9:  return n;
      4'd10: return r;
      4'd11: return rd;
      4'd12: return n << t[3:0];
      4'd13: return t - 16'd1;
      4'd14: return 16'(depth);
      default: return n - t;
    endcase
  endfunction

  // Reference model: interprets one instruction per cycle and checks outputs.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      m_pc = 0; m_T = 0; m_dsp = 0; m_rsp = 0; m_valid = 0;
      for (int i = 0; i < 16; i++) begin m_ds[i] = 0; m_rs[i] = 0; end
      chk("rst_iaddr", 32'(iaddr), 0);
      chk("rst_dwrite", 32'(dwrite), 0);
      chk("rst_daddr", 32'(daddr), 0);
      chk("rst_ddata_write", 32'(ddata_write), 0);
    end else begin
      chk("m_daddr", 32'(daddr), 32'(m_T[7:0]));
      chk("m_ddata_write", 32'(ddata_write), 32'(m_ds[m_dsp]));
      insn = idata; mn = m_ds[m_dsp]; mr = m_rs[m_rsp];
      npc = m_pc + 10'd1; exp_dw = 0;
      if (!m_valid) begin
        npc = m_pc;
        m_valid = 1;
      end else if (!insn[15]) begin
        m_dsp = (m_dsp + 1) % 16; m_ds[m_dsp] = m_T; m_T = {1'b0, insn[14:0]};
      end else if (insn[14:13] == 2'b00) begin
        npc = insn[9:0];
      end else if (insn[14:13] == 2'b01) begin
        if (m_T == 0) npc = insn[9:0];
        m_T = mn; m_dsp = (m_dsp + 15) % 16;
      end else if (insn[14:13] == 2'b10) begin
        m_rsp = (m_rsp + 1) % 16; m_rs[m_rsp] = {6'd0, npc}; npc = insn[9:0];
      end else begin
        exp_dw = insn[9];
        res = alu(insn[6:3], m_T, mn, mr, m_ram[m_T[7:0]], m_dsp);
        if (insn[9]) m_ram[m_T[7:0]] = mn;
        nd = (m_dsp + delta(insn[1:0]) + 16) % 16;
        nr = (m_rsp + delta(insn[8:7]) + 16) % 16;
        if (insn[12]) npc = mr[9:0];
        if (insn[11]) m_ds[nd] = m_T;
        if (insn[10]) m_rs[nr] = m_T;
        m_T = res; m_dsp = nd; m_rsp = nr;
      end
      chk("m_iaddr", 32'(iaddr), 32'(npc));
      chk("m_dwrite", 32'(dwrite), 32'(exp_dw));
      m_pc = npc;
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 16'hE040;
  endtask

  task automatic restart();
    @(posedge clk); #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
  endtask

  initial begin
    int guard, cnt;
    logic [15:0] st_addr, st_data;
    reset = 1'b0; idata = 16'h0000;
    clear_rom();
    for (int i = 0; i < 256; i++) begin ram[i] = 0; m_ram[i] = 0; end
    repeat (2) @(negedge clk);
    chk("reset_iaddr", 32'(iaddr), 0);

    // NOP stream: bubble at 0, then 1,2,3..., wrap 1023 -> 0
    restart();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("seq_iaddr", 32'(iaddr), 32'(k));
      chk("seq_dwrite", 32'(dwrite), 0);
    end
    guard = 0;
    while (iaddr !== 10'h3FF && guard < 1100) begin @(negedge clk); guard++; end
    chk("wrap_reach", 32'(guard < 1100), 1);
    @(negedge clk); chk("wrap_iaddr", 32'(iaddr), 0);
    @(negedge clk); chk("wrap_iaddr_next", 32'(iaddr), 1);

    // 1 2 +
    clear_rom(); rom[0] = 16'h0001; rom[1] = 16'h0002; rom[2] = 16'hE007;
    restart();
    repeat (5) @(negedge clk);
    chk("add_daddr", 32'(daddr), 32'h03);
    chk("add_n", 32'(ddata_write), 0);

    // 5 16 store
    clear_rom(); rom[0] = 16'h0005; rom[1] = 16'h0010; rom[2] = 16'hE242;
    restart();
    cnt = 0; st_addr = 16'hFFFF; st_data = 16'hFFFF;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (dwrite === 1'b1) begin cnt++; st_addr = 16'(daddr); st_data = ddata_write; end
    end
    chk("store_count", 32'(cnt), 1);
    chk("store_addr", 32'(st_addr), 32'h10);
    chk("store_data", 32'(st_data), 32'h0005);
    chk("store_ram", 32'(ram[8'h10]), 32'h0005);

    // load from RAM
    clear_rom(); rom[0] = 16'hE058; ram[0] = 16'hBEEF; m_ram[0] = 16'hBEEF;
    restart();
    repeat (3) @(negedge clk);
    chk("load_daddr", 32'(daddr), 32'hEF);

    // call 0x100, return
    clear_rom(); rom[0] = 16'hC100; rom[10'h100] = 16'hF1C0;
    restart();
    repeat (2) @(negedge clk);
    chk("call_iaddr", 32'(iaddr), 32'h100);
    @(negedge clk);
    chk("ret_iaddr", 32'(iaddr), 32'h001);

    // 0branch taken and not taken, then mid-program reset
    clear_rom(); rom[0] = 16'h0000; rom[1] = 16'hA010; rom[10'h10] = 16'h0001;
    rom[10'h11] = 16'hA020;
    restart();
    repeat (3) @(negedge clk);
    chk("zbr_taken", 32'(iaddr), 32'h010);
    repeat (2) @(negedge clk);
    chk("zbr_fall", 32'(iaddr), 32'h012);
    @(posedge clk); #3 reset = 1'b0;
    #1 chk("midrst_iaddr", 32'(iaddr), 0);

    // ALU mix, checked cycle by cycle against the model
    clear_rom();
    rom[0]  = 16'h1234; rom[1]  = 16'h0F0F; rom[2]  = 16'hE00B; rom[3]  = 16'h0003;
    rom[4]  = 16'hE063; rom[5]  = 16'h7FFF; rom[6]  = 16'hE01B; rom[7]  = 16'hE020;
    rom[8]  = 16'h0004; rom[9]  = 16'hE03B; rom[10] = 16'hE841; rom[11] = 16'hE033;
    rom[12] = 16'hE871; rom[13] = 16'h0009; rom[14] = 16'hE4CB; rom[15] = 16'hE851;
    rom[16] = 16'hE9D1; rom[17] = 16'hE07B; rom[18] = 16'hE02B; rom[19] = 16'hE068;
    rom[20] = 16'hE007;
    restart();
    repeat (26) @(negedge clk);

    // reset during a store cycle suppresses the write
    clear_rom(); rom[0] = 16'h0005; rom[1] = 16'h0010; rom[2] = 16'hE242;
    ram[8'h10] = 16'h0000;
    restart();
    repeat (4) @(negedge clk);
    chk("abort_pre", 32'(dwrite), 1);
    #2 reset = 1'b0;
    #1 chk("abort_dwrite", 32'(dwrite), 0);
    chk("abort_iaddr", 32'(iaddr), 0);
    @(posedge clk); #1 chk("abort_ram", 32'(ram[8'h10]), 0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
